// File: rtl/gpio_debounce_pkg.sv
// gpio_pkg: default widths and shared types for the gpio_debounce input conditioner
package gpio_pkg;
   localparam int GPIO_NUM_BITS       = 32;
   localparam int GPIO_SYNC_STAGES    = 2;
   localparam int GPIO_PRESCALE_WIDTH = 16;
   localparam int GPIO_STABLE_WIDTH   = 4;
   typedef logic [GPIO_STABLE_WIDTH-1:0] stable_cnt_t;
endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: synchroniser, stability counter, ipin flop and edge pulses for one bit
// Edge pulses are built only when GPIO_DEBOUNCE_EDGE_EN is defined.
module gpio_debounce_bit
   import gpio_pkg::*;
#(
   parameter int SYNC_STAGES  = GPIO_SYNC_STAGES,
   parameter int STABLE_WIDTH = GPIO_STABLE_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pin_raw,
   input  logic                    en,
   input  logic                    tick,
   input  logic [STABLE_WIDTH-1:0] limit,
   output logic                    ipin,
   output logic                    rise,
   output logic                    fall
);
   logic [SYNC_STAGES-1:0]  sync;
   logic [STABLE_WIDTH-1:0] cnt, cnt_nxt;
   logic [STABLE_WIDTH:0]   eff_limit, cnt_inc;
   logic                    s, ipin_nxt;
   assign s         = sync[SYNC_STAGES-1];
   assign eff_limit = (limit == '0) ? (STABLE_WIDTH+1)'(1) : {1'b0, limit};
   assign cnt_inc   = {1'b0, cnt} + (STABLE_WIDTH+1)'(1);
   // cnt never exceeds eff_limit-1, so the widened increment cannot overflow
   always_comb begin
      ipin_nxt = ipin;
      cnt_nxt  = cnt;
      if (!en) begin
         ipin_nxt = s;
         cnt_nxt  = '0;
      end else if (s == ipin) begin
         cnt_nxt = '0;
      end else if (tick) begin
         ipin_nxt = (cnt_inc >= eff_limit) ? s : ipin;
         cnt_nxt  = (cnt_inc >= eff_limit) ? '0 : cnt_inc[STABLE_WIDTH-1:0];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
         cnt  <= '0;
         ipin <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], pin_raw};
         cnt  <= cnt_nxt;
         ipin <= ipin_nxt;
      end
   end
`ifdef GPIO_DEBOUNCE_EDGE_EN
   logic ipin_d;
   always_ff @(posedge clk) ipin_d <= rst ? 1'b0 : ipin;
   assign rise = ipin & ~ipin_d;
   assign fall = ~ipin & ipin_d;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif
endmodule

// File: rtl/gpio_debounce.sv
// gpio_debounce: synchronise and optionally debounce raw GPIO pads into clean ipins
// Rise/fall pulses are generated only when GPIO_DEBOUNCE_EDGE_EN is defined.
module gpio_debounce
   import gpio_pkg::*;
#(
   parameter int NUM_BITS       = GPIO_NUM_BITS,
   parameter int SYNC_STAGES    = GPIO_SYNC_STAGES,
   parameter int PRESCALE_WIDTH = GPIO_PRESCALE_WIDTH,
   parameter int STABLE_WIDTH   = GPIO_STABLE_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_BITS-1:0]       pins_raw,
   input  logic [NUM_BITS-1:0]       debounce_en,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic [STABLE_WIDTH-1:0]   stable_limit,
   output logic [NUM_BITS-1:0]       ipins,
   output logic [NUM_BITS-1:0]       rise,
   output logic [NUM_BITS-1:0]       fall
);
   logic [PRESCALE_WIDTH-1:0] pcnt;
   logic                      tick;
   // >= rather than == so a lowered prescale ticks at once instead of wrapping
   assign tick = pcnt >= prescale;
   always_ff @(posedge clk) pcnt <= (rst || tick) ? '0 : pcnt + 1'b1;
   for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
      gpio_debounce_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .STABLE_WIDTH(STABLE_WIDTH)
      ) u_bit (
         .clk    (clk),
         .rst    (rst),
         .pin_raw(pins_raw[i]),
         .en     (debounce_en[i]),
         .tick   (tick),
         .limit  (stable_limit),
         .ipin   (ipins[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end
endmodule
